// File: rtl/vga_sync_decoder_if.sv
// Bundles the VGA input stream (as driven to the DAC) with the decoded pixel
// and status outputs. The source side (timing generator or bench) uses the
// master modport; the decoder uses the slave modport.
interface vga_sync_decoder_if;
  logic       VGA_HS;
  logic       VGA_VS;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic       pix_valid;
  logic       frame_start;
  logic       locked;
  logic       sync_err;
  logic [7:0] err_count;

  modport master (
    output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
    input  pix_x, pix_y, pix_r, pix_g, pix_b,
    input  pix_valid, frame_start, locked, sync_err, err_count
  );

  modport slave (
    input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
    output pix_x, pix_y, pix_r, pix_g, pix_b,
    output pix_valid, frame_start, locked, sync_err, err_count
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side decoder for a VGA HS/VS/RGB stream.
// Recovers (pix_x, pix_y, colour), checks sync timing and reports lock/errors.
// Timing defaults are the 640x480 mode; they are parameters so the same
// decoder can follow a scaled-down stream.
//
// state   | meaning
// --------+---------------------------------------------------------------
// SEARCH  | no trust in the counters; waiting for a VS falling edge
// ACQUIRE | counters aligned on one VS fall; timing checked, lock on next
// LOCKED  | timing verified; pixel outputs and frame_start enabled
module vga_sync_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input logic               VGA_CLK,
  input logic               reset_n,
  vga_sync_decoder_if.slave vga
);

  localparam logic [9:0] CNT_MAX     = 10'h3FF;
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] H_FIRST     = 10'(H_START);
  localparam logic [9:0] H_END       = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] V_FIRST     = 10'(V_START);
  localparam logic [9:0] V_END       = 10'(V_START + V_ACTIVE);
  localparam logic [7:0] ERR_MAX     = 8'hFF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state;

  logic        hs_q1, hs_q2;
  logic        vs_q1, vs_q2;
  logic        vs_line;
  logic [23:0] rgb_q1, rgb_q2;
  logic [9:0]  h_cnt, v_cnt;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [9:0]  h_next, v_next;
  logic        err_a, err_b, err_c, err_d, err_e;
  logic        viol;
  logic        lock_next;
  logic        active;

  // Edge detection and counter next-values. h_cnt/v_cnt always describe the
  // pixel held in the stage-2 registers, while edges are seen on the pixel
  // entering stage 1, so "the clock the edge is seen" updates the counters
  // to describe that new pixel.
  always_comb begin
    hs_fall = hs_q2 & ~hs_q1;
    hs_rise = ~hs_q2 & hs_q1;
    vs_fall = vs_q2 & ~vs_q1;
    vs_rise = ~vs_q2 & vs_q1;

    if (hs_fall) begin
      h_next = '0;
    end else if (h_cnt == CNT_MAX) begin
      h_next = h_cnt;
    end else begin
      h_next = h_cnt + 10'd1;
    end

    if (!hs_fall) begin
      v_next = v_cnt;
    end else if (!vs_q1 && vs_line) begin
      v_next = '0;
    end else if (v_cnt == CNT_MAX) begin
      v_next = v_cnt;
    end else begin
      v_next = v_cnt + 10'd1;
    end
  end

  // Timing violation detection and lock decision for the coming output clock.
  // VS edges coinciding with an HS fall belong to the new line, hence v_next
  // for the rise check; the fall check wants the last line of the old frame.
  always_comb begin
    err_a = hs_fall && (h_cnt != H_LAST);
    err_b = !hs_fall && (h_cnt == H_LAST);
    err_c = hs_rise && (h_cnt != H_SYNC_LAST);
    err_d = vs_fall && (v_cnt != V_LAST);
    err_e = vs_rise && (v_next != V_SYNC_END);
    viol  = (state != SEARCH) && (err_a || err_b || err_c || err_d || err_e);

    lock_next = !viol && ((state == LOCKED) || ((state == ACQUIRE) && vs_fall));

    active = (h_cnt >= H_FIRST) && (h_cnt < H_END) &&
             (v_cnt >= V_FIRST) && (v_cnt < V_END);
  end

  // Input pipeline and line/pixel counters. Sync copies reset low so that no
  // edge is reported until a real high level has been sampled; vs_line resets
  // high so the first VS-low line after reset can align v_cnt.
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      hs_q1   <= 1'b0;
      hs_q2   <= 1'b0;
      vs_q1   <= 1'b0;
      vs_q2   <= 1'b0;
      vs_line <= 1'b1;
      rgb_q1  <= '0;
      rgb_q2  <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      hs_q1   <= vga.VGA_HS;
      hs_q2   <= hs_q1;
      vs_q1   <= vga.VGA_VS;
      vs_q2   <= vs_q1;
      rgb_q1  <= {vga.VGA_R, vga.VGA_G, vga.VGA_B};
      rgb_q2  <= rgb_q1;
      h_cnt   <= h_next;
      v_cnt   <= v_next;
      if (hs_fall) begin
        vs_line <= vs_q1;
      end
    end
  end

  // Lock FSM with registered status and pixel outputs.
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state           <= SEARCH;
      vga.locked      <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.sync_err    <= 1'b0;
      vga.err_count   <= '0;
      vga.pix_valid   <= 1'b0;
      vga.pix_x       <= '0;
      vga.pix_y       <= '0;
      vga.pix_r       <= '0;
      vga.pix_g       <= '0;
      vga.pix_b       <= '0;
    end else begin
      vga.sync_err    <= viol;
      vga.frame_start <= 1'b0;
      if (viol && (vga.err_count != ERR_MAX)) begin
        vga.err_count <= vga.err_count + 8'd1;
      end

      case (state)
        SEARCH: begin
          if (vs_fall) begin
            state <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (viol) begin
            state <= SEARCH;
          end else if (vs_fall) begin
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (viol) begin
            state <= SEARCH;
          end else if (vs_fall) begin
            vga.frame_start <= 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase

      vga.locked <= lock_next;
      if (lock_next && active) begin
        vga.pix_valid <= 1'b1;
        vga.pix_x     <= h_cnt - H_FIRST;
        vga.pix_y     <= v_cnt - V_FIRST;
        vga.pix_r     <= rgb_q2[23:16];
        vga.pix_g     <= rgb_q2[15:8];
        vga.pix_b     <= rgb_q2[7:0];
      end else begin
        vga.pix_valid <= 1'b0;
        vga.pix_x     <= '0;
        vga.pix_y     <= '0;
        vga.pix_r     <= '0;
        vga.pix_g     <= '0;
        vga.pix_b     <= '0;
      end
    end
  end

endmodule
